// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the multiplexed 7-segment display path.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for BCD 0..9, blank and dash.
//   - View select encodings (which four time digits are shown).
//   - Edit field encodings (which field blinks while editing).
//   - Digit index that carries the colon dot.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic VIEW_HHMM = 1'b0;
  localparam logic VIEW_MMSS = 1'b1;

  localparam logic FIELD_MIN  = 1'b0;
  localparam logic FIELD_HOUR = 1'b1;

  localparam logic [1:0] COLON_IDX = 2'd2;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd  in  4  digit value; 10..15 are not valid BCD and show a dash
//   seg  out 7  {g,f,e,d,c,b,a}, active low
module bcd_to_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import seven_seg_pkg::*;

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: drives a 4-digit common-anode multiplexed 7-segment
// display from the six BCD digits of the time-keeping block.
// Optional build macro: SEVEN_SEG_LZ_BLANK_EN -- when defined, the leftmost
// digit is blanked while it holds 0 (leading-zero suppression).
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   h2,h1      in   4  hour tens/ones (BCD)
//   m2,m1      in   4  minute tens/ones (BCD)
//   s2,s1      in   4  second tens/ones (BCD)
//   view       in   1  0 = HH:MM, 1 = MM:SS
//   edit_en    in   1  edit mode; selected field blinks
//   pos        in   1  edited field: 0 = minutes, 1 = hours
//   alarm_hit  in   1  alarm match; colon flashes at the blink rate
//   an         out  4  anode enables, active low, an[3] = leftmost digit
//   seg        out  7  {g,f,e,d,c,b,a}, active low
//   dp         out  1  decimal point (colon), active low
// All outputs are registered: they reflect the digit index and inputs
// sampled on the previous clock edge.
module seven_seg_scanner #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       view,
  input  logic       edit_en,
  input  logic       pos,
  input  logic       alarm_hit,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  import seven_seg_pkg::*;

  localparam int REFRESH_TC = CLK_HZ / REFRESH_HZ;
  localparam int BLINK_TC   = CLK_HZ / (2 * BLINK_HZ);
  localparam int RCW        = $clog2(REFRESH_TC);
  localparam int BCW        = $clog2(BLINK_TC);

  if (REFRESH_TC < 2) begin : g_bad_refresh
    $error("seven_seg_scanner: CLK_HZ/REFRESH_HZ must be >= 2");
  end
  if (BLINK_TC < 2) begin : g_bad_blink
    $error("seven_seg_scanner: CLK_HZ/(2*BLINK_HZ) must be >= 2");
  end

  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_TC - 1);
  localparam logic [BCW-1:0] BLINK_LAST   = BCW'(BLINK_TC - 1);

  logic [RCW-1:0] refresh_cnt;
  logic [BCW-1:0] blink_cnt;
  logic [1:0]     idx;
  logic           blink_phase;

  logic [3:0] digit;
  logic [6:0] digit_seg;
  logic       blink_blank;
  logic       lz_blank;
  logic       blank;

  // Digit routing: idx 3 is leftmost. The upper pair (idx 3,2) holds hours
  // in HH:MM and minutes in MM:SS; the lower pair follows one field down.
  always_comb begin
    digit = 4'd0;
    if (view == VIEW_HHMM) begin
      case (idx)
        2'd3:    digit = h2;
        2'd2:    digit = h1;
        2'd1:    digit = m2;
        default: digit = m1;
      endcase
    end else begin
      case (idx)
        2'd3:    digit = m2;
        2'd2:    digit = m1;
        2'd1:    digit = s2;
        default: digit = s1;
      endcase
    end
  end

  bcd_to_seg u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

  // A digit blinks when it belongs to the edited field. In MM:SS the hours
  // are off screen, so pos=hours matches nothing there.
  always_comb begin
    blink_blank = 1'b0;
    if (edit_en && blink_phase) begin
      if (view == VIEW_HHMM)
        blink_blank = idx[1] ? (pos == FIELD_HOUR) : (pos == FIELD_MIN);
      else
        blink_blank = idx[1] && (pos == FIELD_MIN);
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  assign lz_blank = (idx == 2'd3) && (digit == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  assign blank = blink_blank || lz_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      idx         <= 2'd0;
      blink_phase <= 1'b0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RCW'(1);
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BCW'(1);
      end

      if (blank) begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= digit_seg;
        // Colon is lit on its digit, except during the off half of an alarm flash.
        dp  <= ~((idx == COLON_IDX) && !(alarm_hit && blink_phase));
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with CLK_HZ=16, REFRESH_HZ=4,
// BLINK_HZ=1: each digit is held for 4 cycles and the blink phase flips
// every 8 cycles. k counts clock edges since reset release; the outputs
// seen after edge k belong to idx ((k-1)/4)%4 and phase ((k-1)/8)%2.
module tb_seven_seg_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] h2, h1, m2, m1, s2, s1;
  logic       view, edit_en, pos, alarm_hit;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks;
  int n_fails;
  int k;

  seven_seg_scanner #(
    .CLK_HZ     (16),
    .REFRESH_HZ (4),
    .BLINK_HZ   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .h2        (h2),
    .h1        (h1),
    .m2        (m2),
    .m1        (m1),
    .s2        (s2),
    .s1        (s1),
    .view      (view),
    .edit_en   (edit_en),
    .pos       (pos),
    .alarm_hit (alarm_hit),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written expected tables (independent of the design package).
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s (k=%0d): observed %b expected %b", tag, k, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},  7'(an),  7'b0001111);
    chk({tag, "_seg"}, seg,     7'b1111111);
    chk({tag, "_dp"},  7'(dp),  7'd1);
  endtask

  // Runs n cycles; d3..d0 are the digits expected left to right, blink_mask
  // marks digits of the edited field (blanked while phase=1), lz requests
  // leading-zero blanking of idx 3, alarm selects the flashing colon.
  task automatic run_check(input string tag, input int n,
                           input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0,
                           input logic [3:0] blink_mask, input logic lz,
                           input logic alarm);
    logic [1:0] ix;
    logic       ph;
    logic [3:0] d;
    logic       blk;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int i = 0; i < n; i++) begin
      tick();
      ix = 2'(((k - 1) >> 2) & 3);
      ph = 1'(((k - 1) >> 3) & 1);
      case (ix)
        2'd3:    d = d3;
        2'd2:    d = d2;
        2'd1:    d = d1;
        default: d = d0;
      endcase
      blk   = (ph && blink_mask[ix]) || (lz && ix == 2'd3 && d == 4'd0);
      e_an  = blk ? 4'b1111 : an_tab[ix];
      e_seg = blk ? 7'b1111111 : pat(d);
      e_dp  = (blk || ix != 2'd2 || (alarm && ph)) ? 1'b1 : 1'b0;
      chk({tag, "_an"},  7'(an), 7'(e_an));
      chk({tag, "_seg"}, seg,    e_seg);
      chk({tag, "_dp"},  7'(dp), 7'(e_dp));
    end
  endtask

  // ---------------- stimulus / scoreboard ----------------
  logic lz_on;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    k        = 0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    lz_on = 1'b1;
`else
    lz_on = 1'b0;
`endif
    rst = 1'b1;
    h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd0; s2 = 4'd0; s1 = 4'd0;
    view = 1'b0; edit_en = 1'b0; pos = 1'b0; alarm_hit = 1'b0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset("reset");
    end
    rst = 1'b0;
    k   = 0;

    // 12:30 in HH:MM; anode sequence 1110,1101,1011,0111 twice.
    run_check("hhmm", 32, 4'd1, 4'd2, 4'd3, 4'd0, 4'b0000, 1'b0, 1'b0);

    // MM:SS with 58:07.
    view = 1'b1; m2 = 4'd5; m1 = 4'd8; s2 = 4'd0; s1 = 4'd7;
    run_check("mmss", 22, 4'd5, 4'd8, 4'd0, 4'd7, 4'b0000, 1'b0, 1'b0);
    // k=54 sits on idx 1 showing s2=0; flip view mid-digit.
    view = 1'b0;
    tick();
    chk("flip_an",  7'(an), 7'b0001101);
    chk("flip_seg", seg,    pat(4'd5));

    // Edit hours in HH:MM (12:58): upper pair blinks.
    edit_en = 1'b1; pos = 1'b1;
    run_check("edit_hr", 38, 4'd1, 4'd2, 4'd5, 4'd8, 4'b1100, 1'b0, 1'b0);
    // k=93: idx 3, phase 1, digit blanked; drop edit_en and it reappears.
    edit_en = 1'b0;
    tick();
    chk("edit_off_an",  7'(an), 7'b0000111);
    chk("edit_off_seg", seg,    pat(4'd1));
    chk("edit_off_dp",  7'(dp), 7'd1);

    // Edit minutes in HH:MM: lower pair blinks.
    edit_en = 1'b1; pos = 1'b0;
    run_check("edit_min", 16, 4'd1, 4'd2, 4'd5, 4'd8, 4'b0011, 1'b0, 1'b0);
    // Hours selected in MM:SS: nothing on screen blinks.
    view = 1'b1; pos = 1'b1; s2 = 4'd4; s1 = 4'd6;
    run_check("edit_hr_mmss", 16, 4'd5, 4'd8, 4'd4, 4'd6, 4'b0000, 1'b0, 1'b0);
    // Minutes selected in MM:SS: upper pair blinks.
    pos = 1'b0;
    run_check("edit_min_mmss", 16, 4'd5, 4'd8, 4'd4, 4'd6, 4'b1100, 1'b0, 1'b0);
    edit_en = 1'b0; view = 1'b0;

    // Alarm flashing colon and an invalid BCD digit shown as dash.
    alarm_hit = 1'b1; m1 = 4'hC;
    run_check("alarm", 32, 4'd1, 4'd2, 4'd5, 4'hC, 4'b0000, 1'b0, 1'b1);
    alarm_hit = 1'b0; m1 = 4'd8;

    // Leading zero on the leftmost digit.
    h2 = 4'd0; h1 = 4'd9; m2 = 4'd0; m1 = 4'd5;
    run_check("lz_zero", 16, 4'd0, 4'd9, 4'd0, 4'd5, 4'b0000, lz_on, 1'b0);
    h2 = 4'd1;
    run_check("lz_one", 16, 4'd1, 4'd9, 4'd0, 4'd5, 4'b0000, lz_on, 1'b0);

    // Reset mid-scan, then scanning and blink phase restart from zero.
    run_check("pre_rst", 6, 4'd1, 4'd9, 4'd0, 4'd5, 4'b0000, lz_on, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset("mid_reset");
    rst = 1'b0;
    k   = 0;
    edit_en = 1'b1; pos = 1'b1;
    run_check("post_rst", 16, 4'd1, 4'd9, 4'd0, 4'd5, 4'b1100, lz_on, 1'b0);
    edit_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
